// File: rtl/mini_uart_pkg.sv
// mini_uart_pkg
// Shared constants and types for the mini_uart serial port:
//   - register word offsets (DATA, DIVT, LSR, DIVR)
//   - line-status bit positions
//   - transmitter / receiver state encodings
//   - reset divisor and the bit-period helper
package mini_uart_pkg;

    localparam logic [2:0] OFF_DATA = 3'd0;
    localparam logic [2:0] OFF_DIVT = 3'd4;
    localparam logic [2:0] OFF_LSR  = 3'd5;
    localparam logic [2:0] OFF_DIVR = 3'd7;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;

    localparam logic [15:0] DIV_RESET = 16'd9;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles in one bit period: (div + 1) * prescale.
    function automatic logic [31:0] bit_period(input logic [15:0] div,
                                               input logic [31:0] prescale);
        return ({16'd0, div} + 32'd1) * prescale;
    endfunction

endpackage

// File: rtl/mini_uart_rx.sv
// mini_uart_rx
// 8N1 receiver: two-flop synchronizer on rxd, start-bit detection with a
// half-bit glitch re-check, bit-centre sampling, and DR/OE/FE generation.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   rxd        serial input (idle high, asynchronous to clk)
//   divr       receive divisor; bit period = (divr+1)*PRESCALE cycles
//   rd_data    DATA register read this cycle (clears DR)
//   rd_lsr     LSR read this cycle (clears OE and FE)
//   data       last correctly framed byte
//   dr/oe/fe   data ready, overrun, framing error
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | half a bit into the start bit; line re-checked at terminal
// RX_DATA  | sampling 8 data bits, one per bit period, LSB first
// RX_STOP  | sampling the stop bit; byte stored or FE raised at terminal
import mini_uart_pkg::*;

module mini_uart_rx #(
    parameter int PRESCALE = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] divr,
    input  logic        rd_data,
    input  logic        rd_lsr,
    output logic [7:0]  data,
    output logic        dr,
    output logic        oe,
    output logic        fe
);

    localparam logic [31:0] PRESCALE_W = 32'(PRESCALE);

    rx_state_t   state;
    logic        sync1, sync2, sync3;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic [31:0] cnt;
    logic [31:0] limit;

    logic [31:0] period;
    logic [31:0] full_limit;
    logic [31:0] half_limit;
    logic        tc;
    logic        frame_ok;
    logic        frame_bad;

    assign period     = bit_period(divr, PRESCALE_W);
    assign full_limit = period - 32'd1;
    assign half_limit = (period >> 1) - 32'd1;
    assign tc         = (cnt == limit);

    // Stop-bit sample decides between storing the byte and flagging FE.
    assign frame_ok  = (state == RX_STOP) && tc && sync2;
    assign frame_bad = (state == RX_STOP) && tc && !sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync3   <= 1'b1;
            state   <= RX_IDLE;
            shift   <= 8'd0;
            bit_idx <= 3'd0;
            cnt     <= 32'd0;
            limit   <= 32'd0;
            data    <= 8'd0;
            dr      <= 1'b0;
            oe      <= 1'b0;
            fe      <= 1'b0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            sync3 <= sync2;

            case (state)
                RX_IDLE: begin
                    if (sync3 && !sync2) begin
                        state <= RX_START;
                        cnt   <= 32'd0;
                        limit <= half_limit;
                    end
                end
                RX_START: begin
                    if (tc) begin
                        if (sync2) begin
                            // line back high: treat as a glitch
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            cnt     <= 32'd0;
                            limit   <= full_limit;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RX_DATA: begin
                    if (tc) begin
                        shift <= {sync2, shift[7:1]};
                        cnt   <= 32'd0;
                        limit <= full_limit;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RX_STOP: begin
                    if (tc) begin
                        state <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= RX_IDLE;
            endcase

            // Clears are written first so a same-cycle completion wins.
            if (rd_data) begin
                dr <= 1'b0;
            end
            if (rd_lsr) begin
                oe <= 1'b0;
                fe <= 1'b0;
            end
            if (frame_ok) begin
                data <= shift;
                dr   <= 1'b1;
                // a byte being read this cycle is consumed, not overrun
                if (dr && !rd_data) begin
                    oe <= 1'b1;
                end
            end
            if (frame_bad) begin
                fe <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mini_uart.sv
// mini_uart
// Memory-mapped 8N1 serial port with a single-cycle bus slave.
// Registers (word offset): 0 DATA, 4 DIVT, 5 LSR (read-only), 7 DIVR.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   off        register word offset (address bits [4:2])
//   din        write data
//   dout       read data, combinational from off
//   stb, we    bus strobe and write enable
//   ack        acknowledge, equal to stb
//   rxd        serial input, idle high
//   txd        serial output, idle high
//
// state    | meaning
// ---------+-------------------------------------------------------------
// TX_IDLE  | transmitter empty (THRE=1), txd held high
// TX_START | driving the start bit (0)
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving the stop bit (1); THRE sets when it completes
import mini_uart_pkg::*;

module mini_uart #(
    parameter int PRESCALE = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  off,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        stb,
    input  logic        we,
    output logic        ack,
    input  logic        rxd,
    output logic        txd
);

    localparam logic [31:0] PRESCALE_W = 32'(PRESCALE);

    logic [15:0] divt;
    logic [15:0] divr;

    tx_state_t   tx_state;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bit;
    logic [31:0] tx_cnt;
    logic [31:0] tx_limit;
    logic [31:0] tx_next_limit;
    logic        tx_tc;
    logic        thre;

    logic        wr;
    logic        rd;
    logic        wr_data;
    logic        rd_data;
    logic        rd_lsr;

    logic [7:0]  rx_data;
    logic        dr;
    logic        oe;
    logic        fe;

    logic        unused_din;

    assign ack     = stb;
    assign wr      = stb && we;
    assign rd      = stb && !we;
    assign wr_data = wr && (off == OFF_DATA);
    assign rd_data = rd && (off == OFF_DATA);
    assign rd_lsr  = rd && (off == OFF_LSR);

    assign unused_din = &{1'b0, din[31:16]};

    assign thre  = (tx_state == TX_IDLE);
    assign tx_tc = (tx_cnt == tx_limit);

    // Limit is captured per bit, so a DIVT write only affects later bits.
    assign tx_next_limit = bit_period(divt, PRESCALE_W) - 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            divt     <= DIV_RESET;
            divr     <= DIV_RESET;
            tx_state <= TX_IDLE;
            tx_shift <= 8'd0;
            tx_bit   <= 3'd0;
            tx_cnt   <= 32'd0;
            tx_limit <= 32'd0;
            txd      <= 1'b1;
        end else begin
            if (wr && (off == OFF_DIVT)) begin
                divt <= din[15:0];
            end
            if (wr && (off == OFF_DIVR)) begin
                divr <= din[15:0];
            end

            case (tx_state)
                TX_IDLE: begin
                    if (wr_data) begin
                        tx_shift <= din[7:0];
                        txd      <= 1'b0;
                        tx_cnt   <= 32'd0;
                        tx_limit <= tx_next_limit;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tc) begin
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= 3'd0;
                        tx_cnt   <= 32'd0;
                        tx_limit <= tx_next_limit;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 32'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_tc) begin
                        tx_cnt   <= 32'd0;
                        tx_limit <= tx_next_limit;
                        if (tx_bit == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 32'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_tc) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 32'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        dout = 32'd0;
        case (off)
            OFF_DATA: dout = {24'd0, rx_data};
            OFF_DIVT: dout = {16'd0, divt};
            OFF_LSR: begin
                dout[LSR_DR]   = dr;
                dout[LSR_OE]   = oe;
                dout[LSR_FE]   = fe;
                dout[LSR_THRE] = thre;
            end
            OFF_DIVR: dout = {16'd0, divr};
            default:  dout = 32'd0;
        endcase
    end

    mini_uart_rx #(
        .PRESCALE (PRESCALE)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .divr    (divr),
        .rd_data (rd_data),
        .rd_lsr  (rd_lsr),
        .data    (rx_data),
        .dr      (dr),
        .oe      (oe),
        .fe      (fe)
    );

endmodule

// File: tb/tb_mini_uart.sv
// tb_mini_uart
// Directed self-checking bench for mini_uart (PRESCALE=10).
// Inputs change on the falling clock edge; outputs are sampled 1 time unit
// after a falling edge, away from the active rising edge.
module tb_mini_uart;

    logic        clk;
    logic        rst;
    logic [2:0]  off;
    logic [31:0] din;
    logic [31:0] dout;
    logic        stb;
    logic        we;
    logic        ack;
    logic        rxd;
    logic        txd;

    int tests;
    int fails;

    mini_uart #(.PRESCALE(10)) dut (
        .clk  (clk),
        .rst  (rst),
        .off  (off),
        .din  (din),
        .dout (dout),
        .stb  (stb),
        .we   (we),
        .ack  (ack),
        .rxd  (rxd),
        .txd  (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected txd level for bit slot idx of a frame (0=start, 9=stop).
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    task automatic bus_write(input logic [2:0] o, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; off = o; din = d;
        @(negedge clk);
        stb = 1'b0; we = 1'b0; din = 32'd0;
    endtask

    task automatic bus_read_chk(input string tag, input logic [2:0] o, input logic [31:0] exp);
        stb = 1'b1; we = 1'b0; off = o;
        #1;
        chk(tag, dout, exp);
        chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (100) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; stb = 1'b0; we = 1'b0; off = 3'd0; din = 32'd0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("ack_idle", {31'd0, ack}, 32'd0);
        @(negedge clk);

        // reset values and unmapped offsets
        bus_read_chk("reset_lsr", 3'd5, 32'h20);
        bus_read_chk("reset_data", 3'd0, 32'h0);
        bus_read_chk("reset_divt", 3'd4, 32'd9);
        bus_read_chk("reset_divr", 3'd7, 32'd9);
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_read_chk("unmapped_1", 3'd1, 32'h0);
        bus_read_chk("unmapped_6", 3'd6, 32'h0);

        // transmit 0x12 at 100 cycles/bit, busy write of 0x55 mid-frame
        bus_write(3'd4, 32'd9);
        bus_write(3'd0, 32'h12);
        for (int c = 0; c < 1000; c++) begin
            if (c == 250) begin stb = 1'b1; we = 1'b1; off = 3'd0; din = 32'h55; end
            if (c == 251) begin stb = 1'b0; we = 1'b0; din = 32'd0; end
            if (c == 400) begin stb = 1'b1; we = 1'b0; off = 3'd5; end
            if (c == 401) begin stb = 1'b0; end
            #1;
            chk($sformatf("tx12_c%0d", c), {31'd0, txd}, {31'd0, frame_bit(8'h12, c / 100)});
            if (c == 400) chk("lsr_busy", dout, 32'h00);
            @(negedge clk);
        end
        bus_read_chk("lsr_after_tx", 3'd5, 32'h20);
        for (int c = 0; c < 1100; c++) begin
            #1;
            chk($sformatf("no_second_frame_c%0d", c), {31'd0, txd}, 32'd1);
            @(negedge clk);
        end

        // short divisor: 20 cycles/bit
        bus_write(3'd4, 32'd1);
        bus_read_chk("divt_1", 3'd4, 32'd1);
        bus_write(3'd0, 32'hC3);
        for (int c = 0; c < 200; c++) begin
            #1;
            chk($sformatf("txc3_c%0d", c), {31'd0, txd}, {31'd0, frame_bit(8'hC3, c / 20)});
            @(negedge clk);
        end
        bus_read_chk("lsr_after_txc3", 3'd5, 32'h20);
        bus_write(3'd4, 32'd9);

        // start-bit glitch is rejected
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (150) @(negedge clk);
        bus_read_chk("lsr_glitch", 3'd5, 32'h20);

        // receive 0xA5
        bus_write(3'd7, 32'd9);
        rx_frame(8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        bus_read_chk("lsr_rx_ready", 3'd5, 32'h21);
        bus_read_chk("rx_data_a5", 3'd0, 32'hA5);
        bus_read_chk("lsr_rx_read", 3'd5, 32'h20);

        // overrun: second byte overwrites the first
        rx_frame(8'h3C, 1'b1);
        rx_frame(8'h81, 1'b1);
        repeat (5) @(negedge clk);
        bus_read_chk("lsr_overrun", 3'd5, 32'h23);
        bus_read_chk("rx_data_81", 3'd0, 32'h81);
        bus_read_chk("lsr_after_overrun", 3'd5, 32'h20);

        // framing error with DR already set: byte not stored, DR kept
        rx_frame(8'h5A, 1'b1);
        rx_frame(8'h77, 1'b0);
        repeat (5) @(negedge clk);
        bus_read_chk("lsr_fe_dr", 3'd5, 32'h29);
        bus_read_chk("rx_data_5a", 3'd0, 32'h5A);
        bus_read_chk("lsr_after_fe", 3'd5, 32'h20);

        // framing error with DR clear
        rx_frame(8'h00, 1'b0);
        repeat (5) @(negedge clk);
        bus_read_chk("lsr_fe_only", 3'd5, 32'h28);
        bus_read_chk("lsr_fe_cleared", 3'd5, 32'h20);
        bus_read_chk("rx_data_kept", 3'd0, 32'h5A);

        // reset during transmit data bit 3 (50 cycles/bit, byte 0x00)
        bus_write(3'd4, 32'd4);
        bus_write(3'd7, 32'd3);
        bus_write(3'd0, 32'h00);
        repeat (220) @(negedge clk);
        #1;
        chk("txd_bit3_before_rst", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("txd_after_rst", {31'd0, txd}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        bus_read_chk("lsr_after_rst", 3'd5, 32'h20);
        bus_read_chk("divt_after_rst", 3'd4, 32'd9);
        bus_read_chk("divr_after_rst", 3'd7, 32'd9);
        bus_read_chk("data_after_rst", 3'd0, 32'h0);
        for (int c = 0; c < 300; c++) begin
            #1;
            chk($sformatf("txd_idle_after_rst_c%0d", c), {31'd0, txd}, 32'd1);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
